// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end: frame states,
// scan-code set 2 constants and the scan-code to ASCII lookup.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_t;

   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;

   localparam logic [7:0] ASCII_NONE    = 8'h00;
   localparam logic [7:0] ASCII_SPACE   = 8'h20;
   localparam logic [7:0] ASCII_ZERO    = 8'h30;
   localparam logic [7:0] ASCII_UPPER_A = 8'h41;
   localparam logic [7:0] ASCII_LOWER_A = 8'h61;

   function automatic logic is_shift(input logic [7:0] code);
      return (code == SC_LSHIFT) || (code == SC_RSHIFT);
   endfunction

   // Returns {mapped, ascii}; unmapped codes return all zeros.
   function automatic logic [8:0] scan_to_ascii(input logic [7:0] code, input logic shift);
      logic [4:0] idx;
      logic       letter;
      logic [3:0] digit;
      logic       is_digit;
      logic [8:0] res;
      idx      = '0;
      letter   = 1'b1;
      digit    = '0;
      is_digit = 1'b1;
      res      = '0;
      case (code)
         8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;   8'h23: idx = 5'd3;
         8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;   8'h34: idx = 5'd6;   8'h33: idx = 5'd7;
         8'h43: idx = 5'd8;   8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
         8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;  8'h4D: idx = 5'd15;
         8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;  8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;
         8'h3C: idx = 5'd20;  8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
         8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
         default: letter = 1'b0;
      endcase
      case (code)
         8'h45: digit = 4'd0;  8'h16: digit = 4'd1;  8'h1E: digit = 4'd2;  8'h26: digit = 4'd3;
         8'h25: digit = 4'd4;  8'h2E: digit = 4'd5;  8'h36: digit = 4'd6;  8'h3D: digit = 4'd7;
         8'h3E: digit = 4'd8;  8'h46: digit = 4'd9;
         default: is_digit = 1'b0;
      endcase
      if (letter)
         res = {1'b1, (shift ? ASCII_UPPER_A : ASCII_LOWER_A) + {3'b000, idx}};
      else if (is_digit)
         res = {1'b1, ASCII_ZERO + {4'b0000, digit}};
      else if (code == 8'h29)
         res = {1'b1, ASCII_SPACE};
      return res;
   endfunction

endpackage

// File: rtl/ps2_keyboard_decoder_frame_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, samples on ps2_clk falling
// edges, checks start/parity/stop and aborts stalled frames.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data low on a falling edge)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking stop bit and parity, then back to idle
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FRAME_TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int TW = $clog2(FRAME_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(FRAME_TIMEOUT - 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   clk_s;
   logic                   data_s;
   logic                   fall;
   logic                   timeout;
   frame_state_t           state;
   logic [2:0]             bit_cnt;
   logic [7:0]             sr;
   logic                   parity;
   logic [TW-1:0]          to_cnt;

   assign clk_s   = clk_sync[SYNC_STAGES-1];
   assign data_s  = data_sync[SYNC_STAGES-1];
   assign fall    = clk_prev & ~clk_s;
   assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TO_LAST);

   // Accept is decoded in the stop-edge cycle so the top can register the key on the same edge.
   assign code       = sr;
   assign code_valid = (state == ST_STOP) && fall && data_s && (^{sr, parity});

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         sr        <= '0;
         parity    <= 1'b0;
         to_cnt    <= '0;
         frame_err <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev  <= clk_s;
         frame_err <= 1'b0;

         if (state == ST_IDLE || fall || timeout)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + 1'b1;

         if (timeout) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
         end else if (fall) begin
            case (state)
               ST_IDLE: begin
                  if (!data_s) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  sr      <= {data_s, sr[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     state <= ST_PARITY;
               end
               ST_PARITY: begin
                  parity <= data_s;
                  state  <= ST_STOP;
               end
               ST_STOP: begin
                  state <= ST_IDLE;
                  if (!(data_s && (^{sr, parity})))
                     frame_err <= 1'b1;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// Keyboard front end: turns received scan codes into a held ASCII byte with
// make/break/shift tracking and a one-cycle strobe per accepted make code.
module ps2_keyboard_decoder
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES      = 2,
   parameter int FRAME_TIMEOUT    = 50000,
   parameter int CLEAR_ON_RELEASE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keyboard,
   output logic       key_valid,
   output logic       frame_err
);

   logic [7:0] code;
   logic       code_valid;
   logic       ext;
   logic       brk;
   logic       shift;
   logic [7:0] held_code;
   logic [8:0] lookup;

   ps2_frame_rx #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FRAME_TIMEOUT (FRAME_TIMEOUT)
   ) u_rx (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .code       (code),
      .code_valid (code_valid),
      .frame_err  (frame_err)
   );

   assign lookup = scan_to_ascii(code, shift);

   always_ff @(posedge clk) begin
      if (reset) begin
         keyboard  <= ASCII_NONE;
         key_valid <= 1'b0;
         ext       <= 1'b0;
         brk       <= 1'b0;
         shift     <= 1'b0;
         held_code <= '0;
      end else begin
         key_valid <= 1'b0;
         if (code_valid) begin
            if (code == SC_EXT) begin
               ext <= 1'b1;
            end else if (code == SC_BRK) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               // Extended codes carry no mapped keys, so both their make and break are dropped.
               if (!ext) begin
                  if (brk) begin
                     if (is_shift(code))
                        shift <= 1'b0;
                     if (CLEAR_ON_RELEASE != 0 && code == held_code) begin
                        keyboard  <= ASCII_NONE;
                        held_code <= '0;
                     end
                  end else begin
                     if (is_shift(code))
                        shift <= 1'b1;
                     if (lookup[8]) begin
                        keyboard  <= lookup[7:0];
                        key_valid <= 1'b1;
                        held_code <= code;
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Scoreboard bench for ps2_keyboard_decoder: directed PS/2 frames push expected
// strobes into a queue, a monitor pops and compares on every DUT strobe.
module tb_ps2_keyboard_decoder;

   localparam int SYNC      = 2;
   localparam int TIMEOUT   = 300;
   localparam int HALF      = 20;
   localparam int EV_NONE   = 0;
   localparam int EV_KEY    = 1;
   localparam int EV_ERR    = 2;

   typedef struct {
      int         kind;
      logic [7:0] val;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] keyboard;
   logic       key_valid;
   logic       frame_err;

   exp_t exp_q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   ps2_keyboard_decoder #(
      .SYNC_STAGES      (SYNC),
      .FRAME_TIMEOUT    (TIMEOUT),
      .CLEAR_ON_RELEASE (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .keyboard  (keyboard),
      .key_valid (key_valid),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Monitor: every strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (key_valid || frame_err) begin
         exp_t e;
         check("strobe_exclusive", {31'd0, key_valid & frame_err}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {30'd0, key_valid, frame_err}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("strobe_kind", frame_err ? EV_ERR : EV_KEY, e.kind);
            if (e.kind == EV_KEY)
               check("key_ascii", {24'd0, keyboard}, {24'd0, e.val});
            if (e.cyc >= 0)
               check("strobe_latency", cyc, e.cyc);
         end
      end
   end

   task automatic ps2_bit(input logic b, input logic last, input int kind, input logic [7:0] val);
      ps2_data = b;
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      if (last && kind != EV_NONE) begin
         exp_t e;
         e.kind = kind;
         e.val  = val;
         e.cyc  = cyc + SYNC + 1;
         exp_q.push_back(e);
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] code, input logic flip_par, input logic stop_bit,
                             input int kind, input logic [7:0] val);
      logic par;
      par = ~(^code) ^ flip_par;
      ps2_bit(1'b0, 1'b0, EV_NONE, 8'h00);
      for (int i = 0; i < 8; i++)
         ps2_bit(code[i], 1'b0, EV_NONE, 8'h00);
      ps2_bit(par, 1'b0, EV_NONE, 8'h00);
      ps2_bit(stop_bit, 1'b1, kind, val);
      ps2_data = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      repeat (5) @(negedge clk);
      check("reset_keyboard", {24'd0, keyboard}, 32'h00);
      check("reset_key_valid", {31'd0, key_valid}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      send_frame(8'h24, 1'b0, 1'b1, EV_KEY, 8'h65);
      check("hold_e", {24'd0, keyboard}, 32'h65);

      send_frame(8'h12, 1'b0, 1'b1, EV_NONE, 8'h00);
      send_frame(8'h32, 1'b0, 1'b1, EV_KEY, 8'h42);
      send_frame(8'hF0, 1'b0, 1'b1, EV_NONE, 8'h00);
      send_frame(8'h32, 1'b0, 1'b1, EV_NONE, 8'h00);
      check("release_clears", {24'd0, keyboard}, 32'h00);
      send_frame(8'hF0, 1'b0, 1'b1, EV_NONE, 8'h00);
      send_frame(8'h12, 1'b0, 1'b1, EV_NONE, 8'h00);
      send_frame(8'h32, 1'b0, 1'b1, EV_KEY, 8'h62);

      send_frame(8'h23, 1'b1, 1'b1, EV_ERR, 8'h00);
      check("parity_keeps_key", {24'd0, keyboard}, 32'h62);

      send_frame(8'h16, 1'b0, 1'b0, EV_ERR, 8'h00);
      check("stop_err_keeps_key", {24'd0, keyboard}, 32'h62);

      begin
         exp_t e;
         ps2_bit(1'b0, 1'b0, EV_NONE, 8'h00);
         for (int i = 0; i < 4; i++)
            ps2_bit(1'b1, 1'b0, EV_NONE, 8'h00);
         e.kind = EV_ERR;
         e.val  = 8'h00;
         e.cyc  = -1;
         exp_q.push_back(e);
         repeat (TIMEOUT + 60) @(negedge clk);
      end
      send_frame(8'h2B, 1'b0, 1'b1, EV_KEY, 8'h66);

      send_frame(8'hE0, 1'b0, 1'b1, EV_NONE, 8'h00);
      send_frame(8'h24, 1'b0, 1'b1, EV_NONE, 8'h00);
      check("ext_ignored", {24'd0, keyboard}, 32'h66);
      send_frame(8'h24, 1'b0, 1'b1, EV_KEY, 8'h65);

      send_frame(8'h16, 1'b0, 1'b1, EV_KEY, 8'h31);
      send_frame(8'h16, 1'b0, 1'b1, EV_KEY, 8'h31);
      send_frame(8'h45, 1'b0, 1'b1, EV_KEY, 8'h30);
      send_frame(8'h29, 1'b0, 1'b1, EV_KEY, 8'h20);

      ps2_bit(1'b0, 1'b0, EV_NONE, 8'h00);
      ps2_bit(1'b1, 1'b0, EV_NONE, 8'h00);
      ps2_bit(1'b1, 1'b0, EV_NONE, 8'h00);
      ps2_data = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("midframe_reset_keyboard", {24'd0, keyboard}, 32'h00);
      reset = 1'b0;
      repeat (TIMEOUT + 20) @(negedge clk);
      check("idle_after_reset", {24'd0, keyboard}, 32'h00);
      send_frame(8'h1C, 1'b0, 1'b1, EV_KEY, 8'h61);

      repeat (100) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
